// File: rtl/br_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : br_arbiter
// Brief    : Two-master arbiter/sequencer for the PSRAM burst-RAM command
//            port, with command spacing and a read watchdog.
// Revision : 1.0
// ============================================================================
module br_arbiter #(
    parameter int ADDR_WIDTH   = 21,
    parameter int BURST_BEATS  = 4,
    parameter int CMD_GAP      = 16,
    parameter int READ_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_cmd,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [63:0]           m0_wr_data,
    input  logic [7:0]            m0_data_mask,
    output logic                  m0_grant,
    output logic                  m0_wr_beat,
    output logic                  m0_rd_valid,
    output logic                  m0_done,

    input  logic                  m1_req,
    input  logic                  m1_cmd,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [63:0]           m1_wr_data,
    input  logic [7:0]            m1_data_mask,
    output logic                  m1_grant,
    output logic                  m1_wr_beat,
    output logic                  m1_rd_valid,
    output logic                  m1_done,

    output logic [63:0]           rd_data,

    output logic                  br_cmd,
    output logic                  br_cmd_en,
    output logic [ADDR_WIDTH-1:0] br_addr,
    output logic [63:0]           br_wr_data,
    output logic [7:0]            br_data_mask,
    input  logic [63:0]           br_rd_data,
    input  logic                  br_rd_data_valid,

    output logic                  timeout_err
);

    localparam int c_BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int c_GAP_W  = $clog2(CMD_GAP + 1);
    localparam int c_TO_W   = $clog2(READ_TIMEOUT + 1);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_BEATS - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_EXIT  = c_GAP_W'(CMD_GAP - 2);
    localparam logic [c_TO_W-1:0]   c_TO_LIMIT  = c_TO_W'(READ_TIMEOUT);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR      = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_RD      = 3'd3;
    localparam logic [2:0] c_ST_GAP     = 3'd4;

    logic [2:0]            r_state;
    logic                  r_grant;
    logic                  r_owner;
    logic                  r_last_owner;
    logic                  r_cmd_en;
    logic                  r_br_cmd;
    logic [ADDR_WIDTH-1:0] r_br_addr;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [c_GAP_W-1:0]    r_gap_cnt;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic                  r_done0;
    logic                  r_done1;
    logic                  r_timeout_err;

    logic [2:0]            w_state_next;
    logic                  w_grant_fire;
    logic                  w_new_owner;
    logic                  w_new_cmd;
    logic [ADDR_WIDTH-1:0] w_new_addr;
    logic                  w_finish;
    logic                  w_timeout;
    logic                  w_beat_adv;
    logic                  w_in_read;

    assign w_in_read = (r_state == c_ST_RD_WAIT) || (r_state == c_ST_RD);

    always_comb begin
        w_state_next = r_state;
        w_grant_fire = 1'b0;
        w_new_owner  = r_owner;
        w_new_cmd    = 1'b0;
        w_new_addr   = '0;
        w_finish     = 1'b0;
        w_timeout    = 1'b0;
        w_beat_adv   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant_fire = 1'b1;
                    // On a tie the master that did not own the bus last time wins.
                    if (m0_req && m1_req) begin
                        w_new_owner = ~r_last_owner;
                    end else begin
                        w_new_owner = m1_req;
                    end
                    w_new_cmd    = w_new_owner ? m1_cmd  : m0_cmd;
                    w_new_addr   = w_new_owner ? m1_addr : m0_addr;
                    w_state_next = w_new_cmd ? c_ST_WR : c_ST_RD_WAIT;
                end
            end

            c_ST_WR: begin
                w_beat_adv = 1'b1;
                if (r_beat_cnt == c_LAST_BEAT) begin
                    w_finish     = 1'b1;
                    w_state_next = c_ST_GAP;
                end
            end

            c_ST_RD_WAIT, c_ST_RD: begin
                // A last beat landing on the timeout cycle still counts as success.
                if (br_rd_data_valid && (r_beat_cnt == c_LAST_BEAT)) begin
                    w_finish     = 1'b1;
                    w_state_next = c_ST_GAP;
                end else if (r_to_cnt >= c_TO_LIMIT) begin
                    w_timeout    = 1'b1;
                    w_finish     = 1'b1;
                    w_state_next = c_ST_GAP;
                end else if (br_rd_data_valid) begin
                    w_beat_adv   = 1'b1;
                    w_state_next = c_ST_RD;
                end
            end

            c_ST_GAP: begin
                // Counter is zero in the br_cmd_en cycle; IDLE then issues one cycle later.
                if (r_gap_cnt >= c_GAP_EXIT) begin
                    w_state_next = c_ST_IDLE;
                end
            end

            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant       <= 1'b0;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_cmd_en      <= 1'b0;
            r_br_cmd      <= 1'b0;
            r_br_addr     <= '0;
            r_beat_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_to_cnt      <= '0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cmd_en <= w_grant_fire;
            r_done0  <= w_finish & ~r_owner;
            r_done1  <= w_finish & r_owner;

            if (w_grant_fire) begin
                r_grant      <= 1'b1;
                r_owner      <= w_new_owner;
                r_last_owner <= w_new_owner;
                r_br_cmd     <= w_new_cmd;
                r_br_addr    <= w_new_addr;
                r_beat_cnt   <= '0;
                r_gap_cnt    <= '0;
                r_to_cnt     <= '0;
            end else begin
                if (w_beat_adv) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                if (r_gap_cnt != {c_GAP_W{1'b1}}) begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                if (r_to_cnt != {c_TO_W{1'b1}}) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end

            if (w_finish) begin
                r_grant  <= 1'b0;
                r_br_cmd <= 1'b0;
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign m0_grant     = r_grant & ~r_owner;
    assign m1_grant     = r_grant & r_owner;
    assign m0_wr_beat   = (r_state == c_ST_WR) & ~r_owner;
    assign m1_wr_beat   = (r_state == c_ST_WR) & r_owner;
    assign m0_rd_valid  = br_rd_data_valid & w_in_read & ~r_owner;
    assign m1_rd_valid  = br_rd_data_valid & w_in_read & r_owner;
    assign m0_done      = r_done0;
    assign m1_done      = r_done1;

    assign rd_data      = br_rd_data;

    assign br_cmd       = r_br_cmd;
    assign br_cmd_en    = r_cmd_en;
    assign br_addr      = r_br_addr;
    assign br_wr_data   = r_grant ? (r_owner ? m1_wr_data   : m0_wr_data)   : 64'd0;
    assign br_data_mask = r_grant ? (r_owner ? m1_data_mask : m0_data_mask) : 8'd0;

    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_br_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_arbiter
// Brief    : Self-checking bench for br_arbiter with a scoreboarded
//            controller model and a transaction vector table.
// Revision : 1.0
// ============================================================================
module tb_br_arbiter;

    localparam int ADDR_WIDTH   = 21;
    localparam int BURST_BEATS  = 4;
    localparam int CMD_GAP      = 16;
    localparam int READ_TIMEOUT = 255;

    localparam logic [63:0] c_SALT0 = 64'h0;
    localparam logic [63:0] c_SALT1 = 64'hA5A5_0000_5A5A_0000;

    typedef struct {
        logic                  req0;
        logic                  req1;
        logic                  cmd0;
        logic                  cmd1;
        logic [ADDR_WIDTH-1:0] addr0;
        logic [ADDR_WIDTH-1:0] addr1;
        int                    rd_delay;
        logic                  exp_owner;
        logic                  exp_cmd;
        logic [ADDR_WIDTH-1:0] exp_addr;
    } txn_t;

    typedef struct {
        logic                  owner;
        logic                  cmd;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_exp_t;

    typedef struct {
        logic        owner;
        logic [63:0] data;
        logic [7:0]  mask;
    } beat_exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  m0_req, m0_cmd, m1_req, m1_cmd;
    logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
    logic [63:0]           m0_wr_data, m1_wr_data;
    logic [7:0]            m0_data_mask, m1_data_mask;
    logic                  m0_grant, m0_wr_beat, m0_rd_valid, m0_done;
    logic                  m1_grant, m1_wr_beat, m1_rd_valid, m1_done;
    logic [63:0]           rd_data;
    logic                  br_cmd, br_cmd_en;
    logic [ADDR_WIDTH-1:0] br_addr;
    logic [63:0]           br_wr_data;
    logic [7:0]            br_data_mask;
    logic [63:0]           br_rd_data;
    logic                  br_rd_data_valid;
    logic                  timeout_err;

    br_arbiter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BURST_BEATS (BURST_BEATS),
        .CMD_GAP     (CMD_GAP),
        .READ_TIMEOUT(READ_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req          (m0_req),
        .m0_cmd          (m0_cmd),
        .m0_addr         (m0_addr),
        .m0_wr_data      (m0_wr_data),
        .m0_data_mask    (m0_data_mask),
        .m0_grant        (m0_grant),
        .m0_wr_beat      (m0_wr_beat),
        .m0_rd_valid     (m0_rd_valid),
        .m0_done         (m0_done),
        .m1_req          (m1_req),
        .m1_cmd          (m1_cmd),
        .m1_addr         (m1_addr),
        .m1_wr_data      (m1_wr_data),
        .m1_data_mask    (m1_data_mask),
        .m1_grant        (m1_grant),
        .m1_wr_beat      (m1_wr_beat),
        .m1_rd_valid     (m1_rd_valid),
        .m1_done         (m1_done),
        .rd_data         (rd_data),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_miss = 0;
    int        cyc = 0;
    cmd_exp_t  cmdq[$];
    beat_exp_t wrq[$];
    beat_exp_t rdq[$];
    int        idx0 = 0;
    int        idx1 = 0;
    int        last_cmd_cyc = 0;
    bit        have_cmd = 1'b0;
    int        done_count = 0;
    int        done_cyc = 0;
    logic      done_owner = 1'b0;
    int        last_req_cyc = 0;
    int        model_delay = -1;
    bit        model_pending = 1'b0;
    int        model_start = 0;
    int        stray_left = 0;
    logic      exp_rd_owner = 1'b0;
    logic [104:0] w_outs;

    assign w_outs = {br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask,
                     m0_grant, m1_grant, m0_wr_beat, m1_wr_beat, m0_rd_valid,
                     m1_rd_valid, m0_done, m1_done, timeout_err};

    function automatic logic [63:0] wr_word(input logic [63:0] salt, input int k);
        logic [7:0] b;
        b = 8'((k + 1) * 17);
        return {8{b}} ^ salt;
    endfunction

    function automatic logic [7:0] wr_mask(input logic owner, input int k);
        logic [7:0] m;
        m = 8'h01 << (k & 7);
        return m ^ (owner ? 8'hF0 : 8'h00);
    endfunction

    function automatic txn_t mk(input logic r0, input logic r1, input logic c0, input logic c1,
                                input logic [ADDR_WIDTH-1:0] a0, input logic [ADDR_WIDTH-1:0] a1,
                                input int dly, input logic own, input logic ecmd,
                                input logic [ADDR_WIDTH-1:0] eaddr);
        txn_t t;
        t.req0 = r0; t.req1 = r1; t.cmd0 = c0; t.cmd1 = c1;
        t.addr0 = a0; t.addr1 = a1; t.rd_delay = dly;
        t.exp_owner = own; t.exp_cmd = ecmd; t.exp_addr = eaddr;
        return t;
    endfunction

    assign m0_wr_data   = wr_word(c_SALT0, idx0);
    assign m1_wr_data   = wr_word(c_SALT1, idx1);
    assign m0_data_mask = wr_mask(1'b0, idx0);
    assign m1_data_mask = wr_mask(1'b1, idx1);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters step to the next write beat when the arbiter consumes one.
    always @(posedge clk) begin
        if (rst || m0_done) idx0 <= 0;
        else if (m0_wr_beat) idx0 <= idx0 + 1;
        if (rst || m1_done) idx1 <= 0;
        else if (m1_wr_beat) idx1 <= idx1 + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            have_cmd = 1'b0;
        end else begin
            if (br_cmd_en) begin
                if (have_cmd) chk("cmd_spacing", 128'((cyc - last_cmd_cyc) >= CMD_GAP), 128'd1);
                if (cmdq.size() == 0) begin
                    fail_evt("cmd_unexpected");
                end else begin
                    cmd_exp_t ce;
                    ce = cmdq.pop_front();
                    chk("cmd", {m1_grant, m0_grant, br_cmd, br_addr}, {ce.owner, ~ce.owner, ce.cmd, ce.addr});
                end
                have_cmd = 1'b1;
                last_cmd_cyc = cyc;
            end
            if (m0_wr_beat || m1_wr_beat) begin
                if (wrq.size() == 0) begin
                    fail_evt("wr_beat_unexpected");
                end else begin
                    beat_exp_t be;
                    be = wrq.pop_front();
                    chk("wr_beat", {m1_wr_beat, m0_wr_beat, br_wr_data, br_data_mask},
                        {be.owner, ~be.owner, be.data, be.mask});
                end
            end
            if (m0_rd_valid || m1_rd_valid) begin
                if (rdq.size() == 0) begin
                    fail_evt("rd_valid_unexpected");
                end else begin
                    beat_exp_t be;
                    be = rdq.pop_front();
                    chk("rd_beat", {m1_rd_valid, m0_rd_valid, rd_data}, {be.owner, ~be.owner, be.data});
                end
            end
            if (m0_done || m1_done) begin
                if (m0_done && m1_done) fail_evt("done_both");
                done_count++;
                done_cyc = cyc;
                done_owner = m1_done;
            end
        end
    end

    // Controller read model: answers read commands after model_delay cycles.
    initial begin
        br_rd_data_valid = 1'b0;
        br_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            br_rd_data_valid = 1'b0;
            if (rst) begin
                model_pending = 1'b0;
            end else if (br_cmd_en && !br_cmd && model_delay >= 0) begin
                model_pending = 1'b1;
                model_start = cyc + model_delay;
            end
            if (model_pending && !rst && cyc >= model_start) begin
                br_rd_data_valid = 1'b1;
                br_rd_data = {$urandom, $urandom};
                rdq.push_back('{owner: exp_rd_owner, data: br_rd_data, mask: 8'h00});
                if (cyc >= model_start + BURST_BEATS - 1) model_pending = 1'b0;
            end else if (stray_left > 0) begin
                br_rd_data_valid = 1'b1;
                br_rd_data = {$urandom, $urandom};
                stray_left--;
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int start;
        int n;
        cmdq.push_back('{owner: t.exp_owner, cmd: t.exp_cmd, addr: t.exp_addr});
        if (t.exp_cmd) begin
            for (int k = 0; k < BURST_BEATS; k++) begin
                wrq.push_back('{owner: t.exp_owner, data: wr_word(t.exp_owner ? c_SALT1 : c_SALT0, k),
                                mask: wr_mask(t.exp_owner, k)});
            end
        end
        model_delay = t.rd_delay;
        exp_rd_owner = t.exp_owner;
        m0_cmd = t.cmd0; m0_addr = t.addr0;
        m1_cmd = t.cmd1; m1_addr = t.addr1;
        m0_req = t.req0; m1_req = t.req1;
        last_req_cyc = cyc;
        start = done_count;
        n = 0;
        while (done_count == start && n < 600) begin
            tick();
            n++;
        end
        chk("txn_done_seen", 128'(done_count - start), 128'd1);
        chk("txn_done_owner", 128'(done_owner), 128'(t.exp_owner));
        if (t.exp_cmd) chk("wr_done_latency", 128'(done_cyc - last_cmd_cyc), 128'(BURST_BEATS));
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("txn_drain", {32'(cmdq.size()), 32'(wrq.size()), 32'(rdq.size())}, 128'd0);
    endtask

    initial begin
        txn_t tbl[6];
        int   start;
        int   n;
        logic own;

        tbl[0] = mk(1, 0, 1, 0, 21'h000100, 21'h000000, 0,  0, 1, 21'h000100);
        tbl[1] = mk(0, 1, 0, 0, 21'h000000, 21'h000200, 12, 1, 0, 21'h000200);
        tbl[2] = mk(1, 1, 0, 1, 21'h0000AA, 21'h0001F0, 3,  0, 0, 21'h0000AA);
        tbl[3] = mk(1, 1, 1, 0, 21'h000033, 21'h1FFFFF, 0,  1, 0, 21'h1FFFFF);
        tbl[4] = mk(0, 1, 0, 1, 21'h000000, 21'h000000, 0,  1, 1, 21'h000000);
        tbl[5] = mk(1, 1, 1, 1, 21'h155555, 21'h0AAAAA, 0,  0, 1, 21'h155555);

        rst = 1'b1;
        m0_req = 1'b0; m0_cmd = 1'b0; m0_addr = '0;
        m1_req = 1'b0; m1_cmd = 1'b0; m1_addr = '0;

        repeat (3) tick();
        chk("reset_outputs", 128'(w_outs), 128'd0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 128'(w_outs), 128'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i]);
        end
        chk("no_false_timeout", 128'(timeout_err), 128'd0);

        // Continuous contention: last owner was m0, so m1 leads and they alternate.
        for (int k = 0; k < 4; k++) begin
            own = (k % 2 == 0);
            cmdq.push_back('{owner: own, cmd: 1'b1, addr: own ? 21'h00C0DE : 21'h01ABCD});
            for (int b = 0; b < BURST_BEATS; b++) begin
                wrq.push_back('{owner: own, data: wr_word(own ? c_SALT1 : c_SALT0, b), mask: wr_mask(own, b)});
            end
        end
        m0_cmd = 1'b1; m0_addr = 21'h01ABCD;
        m1_cmd = 1'b1; m1_addr = 21'h00C0DE;
        m0_req = 1'b1; m1_req = 1'b1;
        start = done_count;
        n = 0;
        while (done_count < start + 4 && n < 400) begin
            tick();
            n++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("contention_dones", 128'(done_count - start), 128'd4);
        chk("contention_last_owner", 128'(done_owner), 128'd0);
        chk("contention_drain", {32'(cmdq.size()), 32'(wrq.size()), 32'(rdq.size())}, 128'd0);

        // Read that never returns data: watchdog fires, late data is ignored.
        run_txn(mk(1, 0, 0, 0, 21'h000123, 21'h000000, -1, 0, 0, 21'h000123));
        chk("timeout_done_latency", 128'(done_cyc - last_cmd_cyc), 128'(READ_TIMEOUT + 1));
        chk("timeout_err_set", 128'(timeout_err), 128'd1);
        stray_left = BURST_BEATS;
        repeat (6) tick();
        run_txn(mk(0, 1, 0, 1, 21'h000000, 21'h00FACE, 0, 1, 1, 21'h00FACE));
        chk("timeout_err_sticky", 128'(timeout_err), 128'd1);

        // Reset during the third write beat.
        repeat (CMD_GAP) tick();
        cmdq.push_back('{owner: 1'b0, cmd: 1'b1, addr: 21'h000077});
        for (int b = 0; b < BURST_BEATS; b++) begin
            wrq.push_back('{owner: 1'b0, data: wr_word(c_SALT0, b), mask: wr_mask(1'b0, b)});
        end
        m0_cmd = 1'b1; m0_addr = 21'h000077; m0_req = 1'b1;
        n = 0;
        while (!br_cmd_en && n < 100) begin
            tick();
            n++;
        end
        chk("rst_test_cmd_seen", 128'(br_cmd_en), 128'd1);
        tick();
        tick();
        chk("third_beat_active", 128'(m0_wr_beat), 128'd1);
        rst = 1'b1;
        #1;
        chk("reset_mid_write", 128'(w_outs), 128'd0);
        m0_req = 1'b0;
        cmdq.delete();
        wrq.delete();
        rdq.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_txn(mk(0, 1, 0, 1, 21'h000000, 21'h01E0E0, 0, 1, 1, 21'h01E0E0));

        // Stray read data while idle, then an immediate grant proves IDLE held.
        repeat (CMD_GAP + 4) tick();
        stray_left = BURST_BEATS;
        repeat (8) tick();
        chk("stray_rdq_empty", 128'(rdq.size()), 128'd0);
        run_txn(mk(1, 0, 0, 0, 21'h001000, 21'h000000, 2, 0, 0, 21'h001000));
        chk("idle_grant_latency", 128'(last_cmd_cyc - last_req_cyc), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/br_arbiter.md
# br_arbiter

Two-requester arbiter and sequencer for the PSRAM burst-RAM command port (`br_*` bus of the HS V2 PSRAM controller) in the `clk_out` domain. It lets the RAMIO cache and a second master share the single 64-bit burst interface, for example the flash boot loader or a DMA engine. The block issues commands, streams write beats, steers read beats back to the owner and enforces the controller's minimum command spacing. A read watchdog recovers the bus if read data never arrives.

## Interface
- `ADDR_WIDTH`, 21, width of `br_addr` and requester addresses.
- `BURST_BEATS`, 4, 64-bit data beats per command (burst 32 bytes).
- `CMD_GAP`, 16, minimum cycles between consecutive `br_cmd_en` pulses; must be at least `BURST_BEATS`+2.
- `READ_TIMEOUT`, 255, maximum cycles from read command to last read beat.

Ports:
- `clk`  in  1  controller `clk_out`; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mX_req`  in  1  request, X∈{0,1}; hold it with `mX_cmd`/`mX_addr` stable until `mX_done`.
- `mX_cmd`  in  1  0 read, 1 write.
- `mX_addr`  in  ADDR_WIDTH  burst address.
- `mX_wr_data`  in  64  current write beat.
- `mX_data_mask`  in  8  current beat mask.
- `mX_grant`  out  1  requester X owns the bus.
- `mX_wr_beat`  out  1  current write beat consumed this cycle; advance to the next beat.
- `mX_rd_valid`  out  1  `rd_data` holds a beat for X.
- `mX_done`  out  1  one-cycle pulse at transaction end.
- `rd_data`  out  64  `br_rd_data` passthrough, shared by both requesters.
- `br_cmd`, `br_cmd_en`  out  1 each  to the controller.
- `br_addr`  out  ADDR_WIDTH  to the controller.
- `br_wr_data`  out  64  to the controller.
- `br_data_mask`  out  8  to the controller.
- `br_rd_data`  in  64  from the controller.
- `br_rd_data_valid`  in  1  from the controller.
- `timeout_err`  out  1  sticky; cleared only by `rst`.

## Operation
- States: IDLE, WR, RD_WAIT, RD, GAP.
- IDLE: sample `m0_req` and `m1_req`.
  - If exactly one is high, that requester is granted.
  - If both are high, the requester not granted last wins. The last-owner register resets to 1, so m0 wins the first tie.
  - On a grant, register the owner, set `mX_grant`, pulse `br_cmd_en` for one cycle with `br_cmd`/`br_addr` from the owner, and start the gap counter.
  - Next state is WR if `cmd`=1, otherwise RD_WAIT.
- WR: `br_wr_data`/`br_data_mask` are combinationally muxed from the owner.
  - The first beat goes out in the `br_cmd_en` cycle. `mX_wr_beat` is high for `BURST_BEATS` consecutive cycles starting with that cycle.
  - After the last beat, go to GAP.
- RD_WAIT/RD: `mX_rd_valid` = `br_rd_data_valid` AND owner==X AND state∈{RD_WAIT,RD}.
  - The first valid beat moves RD_WAIT to RD.
  - After `BURST_BEATS` valid beats have been counted, go to GAP.
- Timeout: if `READ_TIMEOUT` cycles pass after `br_cmd_en` without the last beat, set `timeout_err`, pulse `mX_done`, and go to GAP.
- Stray data: `br_rd_data_valid` outside RD_WAIT/RD is dropped and forwarded to no one. Beats beyond `BURST_BEATS` are also dropped.
- GAP: `mX_done` pulses in the cycle after the last beat, and grant drops in that same cycle.
  - Stay in GAP until `CMD_GAP` cycles have elapsed since `br_cmd_en`, then go to IDLE.
  - A requester that keeps `req` high through GAP is treated as making a new request.
- Outputs when no grant is held: `br_wr_data`=0, `br_data_mask`=0, `br_cmd`=0.

## Timing
- Reset values: `br_cmd_en`=0, `br_cmd`=0, `br_addr`=0, all grant/beat/valid/done outputs 0, `timeout_err`=0, state IDLE.
- Reset mid-transaction: the bus is abandoned immediately. Data from an in-flight controller burst is dropped as stray.
- Request at cycle T in IDLE:
  - `grant` and `br_cmd_en` are high at T+1.
  - Write beats occupy T+1..T+BURST_BEATS; done is at T+BURST_BEATS+1.
  - The next `br_cmd_en` is no earlier than T+1+CMD_GAP.
- `br_cmd_en` is never high on two cycles less than `CMD_GAP` apart.
- `rd_data` has zero added latency: it is passthrough, and `mX_rd_valid` is combinational.
- The timeout counter is 8 bits wide, or ⌈log2(READ_TIMEOUT+1)⌉ in general, and saturates.

## Test plan
- m0 write at addr 0x000100 with beats 0x11..,0x22..,0x33..,0x44.. -> one `br_cmd_en` with `br_cmd`=1, `br_addr`=0x100, four beats in order on consecutive cycles, four `m0_wr_beat` pulses, `m0_done` on the 5th cycle after grant.
- m1 read at 0x000200 with the model returning 4 beats after 12 cycles -> `m1_rd_valid` high for exactly those 4 cycles, `m0_rd_valid` stays 0, and the next `br_cmd_en` comes at least 16 cycles after the first.
- m0 and m1 requesting simultaneously and continuously -> grants alternate m0, m1, m0, m1, and every `br_cmd_en` spacing is at least `CMD_GAP`.
- Read where the model never asserts valid -> `m0_done` at cycle 256 after `br_cmd_en`, `timeout_err`=1, the next request is served, and a late burst from the model is not forwarded.
- `rst` asserted during the third write beat -> all outputs 0 in the same cycle; after release, an m1 request is granted and completes normally.
- With no requests, inject `br_rd_data_valid` for 4 cycles -> no `mX_rd_valid`, state stays IDLE.
